// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and line levels for the serial link transmitter and receiver
package serial_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} serial_state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: bit-period counter wrapping every CLKS_PER_BIT cycles, with lookahead of the next bit end
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next
);
  localparam int CW = ($clog2(CLKS_PER_BIT + 1) > 1) ? $clog2(CLKS_PER_BIT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt, cnt_n;
  assign bit_end      = cnt == LAST;
  assign cnt_n        = (clear || bit_end) ? '0 : cnt + 1'b1;
  assign bit_end_next = cnt_n == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= cnt_n;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: valid/ready parallel-to-serial frame transmitter (start, data LSB first, stop)
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             tx_line,
  output logic             tx_busy,
  output logic             tx_done
);
  localparam int IW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  serial_state_t    state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [IW-1:0]    idx, idx_n;
  logic             bit_end, bit_end_next, accept, line_n, done_n;
  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (state == IDLE),
    .bit_end      (bit_end),
    .bit_end_next (bit_end_next)
  );
  assign load_ready = (state == IDLE) || (state == STOP && bit_end);
  assign accept     = load_valid && load_ready;
  assign tx_busy    = state != IDLE;
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    case (state)
      IDLE:
        if (accept) begin
          state_n = START;
          shift_n = load_data;
        end
      START:
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
        end
      DATA:
        if (bit_end) begin
          shift_n = shift >> 1;
          idx_n   = idx + 1'b1;
          state_n = (idx == LAST_IDX) ? STOP : DATA;
        end
      STOP:
        if (bit_end) begin
          state_n = accept ? START : IDLE;
          shift_n = accept ? load_data : shift;
        end
      default: state_n = IDLE;
    endcase
    // line and done are registered from the next state so they align with it
    line_n = (state_n == START) ? START_BIT :
             (state_n == DATA)  ? shift_n[0] :
             (state_n == STOP)  ? STOP_BIT : LINE_IDLE;
    done_n = (state_n == STOP) && bit_end_next;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      idx     <= '0;
      tx_line <= LINE_IDLE;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      idx     <= idx_n;
      tx_line <= line_n;
      tx_done <= done_n;
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed checks of serial_tx at one and four clocks per bit
module tb_serial_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lv1 = 1'b0, lv4 = 1'b0;
  logic [7:0] ld1 = '0, ld4 = '0;
  logic rdy1, line1, busy1, done1;
  logic rdy4, line4, busy4, done4;
  int total = 0;
  int bad = 0;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_data(ld1),
    .load_ready(rdy1), .tx_line(line1), .tx_busy(busy1), .tx_done(done1)
  );
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .load_valid(lv4), .load_data(ld4),
    .load_ready(rdy4), .tx_line(line4), .tx_busy(busy4), .tx_done(done4)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({line1, busy1, done1} !== 3'b100) begin
      bad++;
      $display("FAIL reset_hold line/busy/done=%b want 100", {line1, busy1, done1});
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({line1, busy1, done1, rdy1} !== 4'b1001) begin
        bad++;
        $display("FAIL reset_idle1 cyc=%0d line/busy/done/ready=%b want 1001", i, {line1, busy1, done1, rdy1});
      end
      total++;
      if ({line4, busy4, done4, rdy4} !== 4'b1001) begin
        bad++;
        $display("FAIL reset_idle4 cyc=%0d line/busy/done/ready=%b want 1001", i, {line4, busy4, done4, rdy4});
      end
    end
  endtask

  task automatic test_single;
    logic [9:0] seq;
    logic [7:0] got;
    seq = 10'b1101001010;
    got = '0;
    lv1 = 1'b1;
    ld1 = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) lv1 = 1'b0;
      if (i >= 1 && i <= 8) got[i-1] = line1;
      total++;
      if ({line1, busy1, done1, rdy1} !== {seq[i], 1'b1, i == 9, i == 9}) begin
        bad++;
        $display("FAIL single cyc=%0d line/busy/done/ready=%b want %b", i,
                 {line1, busy1, done1, rdy1}, {seq[i], 1'b1, i == 9, i == 9});
      end
    end
    total++;
    if (got !== 8'hA5) begin
      bad++;
      $display("FAIL single_sample got=%h want a5", got);
    end
    @(negedge clk);
    total++;
    if ({line1, busy1, done1} !== 3'b100) begin
      bad++;
      $display("FAIL single_end line/busy/done=%b want 100", {line1, busy1, done1});
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] s1, s2;
    logic exp;
    s1 = 10'b1001111000;
    s2 = 10'b1111111110;
    lv1 = 1'b1;
    ld1 = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) ld1 = 8'hFF;
      if (i == 10) begin
        lv1 = 1'b0;
        ld1 = 8'h00;
      end
      exp = (i < 10) ? s1[i] : s2[i-10];
      total++;
      if ({line1, busy1, done1, rdy1} !== {exp, 1'b1, i == 9 || i == 19, i == 9 || i == 19}) begin
        bad++;
        $display("FAIL b2b cyc=%0d line/busy/done/ready=%b want %b", i,
                 {line1, busy1, done1, rdy1}, {exp, 1'b1, i == 9 || i == 19, i == 9 || i == 19});
      end
    end
    @(negedge clk);
    total++;
    if ({line1, busy1, done1} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_end line/busy/done=%b want 100", {line1, busy1, done1});
    end
  endtask

  task automatic test_stretched;
    int b;
    logic exp;
    lv4 = 1'b1;
    ld4 = 8'h01;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) lv4 = 1'b0;
      b = i / 4;
      exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : (b == 1);
      total++;
      if ({line4, busy4, done4, rdy4} !== {exp, 1'b1, i == 39, i == 39}) begin
        bad++;
        $display("FAIL stretch cyc=%0d line/busy/done/ready=%b want %b", i,
                 {line4, busy4, done4, rdy4}, {exp, 1'b1, i == 39, i == 39});
      end
    end
    @(negedge clk);
    total++;
    if ({line4, busy4, done4} !== 3'b100) begin
      bad++;
      $display("FAIL stretch_end line/busy/done=%b want 100", {line4, busy4, done4});
    end
  endtask

  task automatic test_mid_reset;
    logic [4:0] pre;
    logic [9:0] seq;
    pre = 5'b01010;
    seq = 10'b1000011110;
    lv1 = 1'b1;
    ld1 = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) lv1 = 1'b0;
      total++;
      if ({line1, busy1} !== {pre[i], 1'b1}) begin
        bad++;
        $display("FAIL midrst_pre cyc=%0d line/busy=%b want %b", i, {line1, busy1}, {pre[i], 1'b1});
      end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({line1, busy1, done1} !== 3'b100) begin
      bad++;
      $display("FAIL midrst_async line/busy/done=%b want 100", {line1, busy1, done1});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({line1, busy1, done1} !== 3'b100) begin
        bad++;
        $display("FAIL midrst_hold cyc=%0d line/busy/done=%b want 100", i, {line1, busy1, done1});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    lv1 = 1'b1;
    ld1 = 8'h0F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) lv1 = 1'b0;
      total++;
      if ({line1, busy1, done1} !== {seq[i], 1'b1, i == 9}) begin
        bad++;
        $display("FAIL midrst_after cyc=%0d line/busy/done=%b want %b", i,
                 {line1, busy1, done1}, {seq[i], 1'b1, i == 9});
      end
    end
    @(negedge clk);
    total++;
    if ({line1, busy1, done1} !== 3'b100) begin
      bad++;
      $display("FAIL midrst_end line/busy/done=%b want 100", {line1, busy1, done1});
    end
  endtask

  task automatic test_stall;
    logic [9:0] s1, s2;
    logic [7:0] got;
    logic exp;
    s1 = 10'b1100000010;
    s2 = 10'b1001101000;
    got = '0;
    lv1 = 1'b1;
    ld1 = 8'h81;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) ld1 = 8'h12;
      if (i == 5) ld1 = 8'h34;
      if (i == 10) begin
        lv1 = 1'b0;
        ld1 = 8'hEE;
      end
      if (i >= 11 && i <= 18) got[i-11] = line1;
      exp = (i < 10) ? s1[i] : s2[i-10];
      total++;
      if ({line1, busy1, done1, rdy1} !== {exp, 1'b1, i == 9 || i == 19, i == 9 || i == 19}) begin
        bad++;
        $display("FAIL stall cyc=%0d line/busy/done/ready=%b want %b", i,
                 {line1, busy1, done1, rdy1}, {exp, 1'b1, i == 9 || i == 19, i == 9 || i == 19});
      end
    end
    total++;
    if (got !== 8'h34) begin
      bad++;
      $display("FAIL stall_sample got=%h want 34", got);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({line1, busy1, done1} !== 3'b100) begin
        bad++;
        $display("FAIL stall_once cyc=%0d line/busy/done=%b want 100", i, {line1, busy1, done1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stretched();
    test_mid_reset();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
